// File: rtl/ysyx_24080006_clint_pkg.sv
// ysyx_24080006_pkg: shared constants and types for the CLINT slave.
//   - CLINT register offsets (decoded from addr[15:0], word aligned)
//   - AXI response codes
//   - read/write FSM state enums
//   - clint_mapped(): offset decode, honours CLINT_CMP_EN (mtimecmp/msip present)
package ysyx_24080006_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_CMP_LO   = 16'h4000;
  localparam logic [15:0] CLINT_CMP_HI   = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI = 16'hBFFC;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } clint_rd_fsm_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } clint_wr_fsm_e;

  function automatic logic clint_mapped(input logic [15:0] off);
    logic hit;
    hit = (off == CLINT_MTIME_LO) || (off == CLINT_MTIME_HI);
`ifdef CLINT_CMP_EN
    hit = hit || (off == CLINT_MSIP) || (off == CLINT_CMP_LO) || (off == CLINT_CMP_HI);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/ysyx_24080006_clint_if.sv
// ysyx_24080006_axi: AXI4 channel bundle (subset used by the CLINT).
//   aw{valid,ready,addr,id,len,size}, w{valid,ready,data,strb,last},
//   b{valid,ready,resp,id}, ar{valid,ready,addr,id,len,size},
//   r{valid,ready,data,resp,last,id}
//   modport master: requester side, modport slave: responder side.
interface ysyx_24080006_axi #(
  parameter int unsigned ID_W = 4
);
  logic            awvalid, awready;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic            wvalid, wready, wlast;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;
  logic            arvalid, arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic            rvalid, rready, rlast;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic [ID_W-1:0] rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arsize, input arready,
    input rvalid, rdata, rresp, rlast, rid, output rready
  );

  modport slave (
    input awvalid, awaddr, awid, awlen, awsize, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input arvalid, araddr, arid, arlen, arsize, output arready,
    output rvalid, rdata, rresp, rlast, rid, input rready
  );
endinterface

// File: rtl/ysyx_24080006_clint_timer.sv
// ysyx_24080006_clint_timer: prescaler + free-running 64-bit mtime.
//   clock, reset : clock, synchronous active-high reset
//   wr_lo_i      : byte-masked write of mtime[31:0]
//   wr_hi_i      : byte-masked write of mtime[63:32]
//   wdata_i      : write data, wstrb_i: byte lanes
//   mtime_o      : current mtime
module ysyx_24080006_clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [63:0] mtime_o
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  assign tick    = (presc_q == PRESC_LAST);
  assign mtime_o = mtime_q;

  // A software write wins over the tick: written lanes take the new bytes and
  // the increment for that cycle is dropped.
  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = mtime_q;
    if (wr_lo_i || wr_hi_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lo_i && wstrb_i[b]) mtime_d[8*b +: 8] = wdata_i[8*b +: 8];
        if (wr_hi_i && wstrb_i[b]) mtime_d[32+8*b +: 8] = wdata_i[8*b +: 8];
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= 16'd0;
      mtime_q <= 64'd0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

endmodule

// File: rtl/ysyx_24080006_clint.sv
// ysyx_24080006_clint: AXI4 slave core-local interruptor.
//   clock, reset : clock, synchronous active-high reset
//   axi_clint    : AXI4 slave port (ysyx_24080006_axi.slave)
//   timer_irq    : registered mtime >= mtimecmp
//   soft_irq     : registered msip[0]
// Build option CLINT_CMP_EN: when defined, mtimecmp/msip and both irqs exist;
// otherwise only mtime is decoded and the irqs are tied low.
module ysyx_24080006_clint
  import ysyx_24080006_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ID_W     = 4
) (
  input  logic            clock,
  input  logic            reset,
  ysyx_24080006_axi.slave axi_clint,
  output logic            timer_irq,
  output logic            soft_irq
);

  clint_rd_fsm_e   rd_state_q, rd_state_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [15:0]     roff_q, roff_d;
  logic [7:0]      rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  clint_wr_fsm_e   wr_state_q, wr_state_d;
  logic            aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [15:0]     woff_q, woff_d;
  logic [7:0]      wlen_q, wlen_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, bresp_d;

  logic [63:0] mtime;
  logic        rd_idle, rd_last;
  logic [15:0] rd_off;
  logic [7:0]  rd_len;
  logic [31:0] rd_sample;
  logic [1:0]  rd_resp, wr_resp;
  logic        aw_hs, w_hs, commit, wr_ok;

  // Base address is decoded upstream; only the window offset matters here.
  logic unused_bits;
  assign unused_bits = ^{axi_clint.araddr[31:16], axi_clint.araddr[1:0],
                         axi_clint.awaddr[31:16], axi_clint.awaddr[1:0],
                         axi_clint.arsize, axi_clint.awsize, BASE};

`ifdef CLINT_CMP_EN
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q, soft_irq_q;
`endif

  // In idle the mux looks at the incoming AR so the first beat is captured at
  // the handshake; later beats resample the latched offset.
  assign rd_idle = (rd_state_q == R_IDLE);
  assign rd_off  = rd_idle ? {axi_clint.araddr[15:2], 2'b00} : roff_q;
  assign rd_len  = rd_idle ? axi_clint.arlen : rlen_q;
  assign rd_last = !rd_idle && (rbeat_q == rlen_q);
  assign rd_resp = (rd_len != 8'd0) ? AXI_SLVERR :
                   clint_mapped(rd_off) ? AXI_OKAY : AXI_DECERR;

  always_comb begin
    rd_sample = 32'd0;
    case (rd_off)
      CLINT_MTIME_LO: rd_sample = mtime[31:0];
      CLINT_MTIME_HI: rd_sample = mtime[63:32];
`ifdef CLINT_CMP_EN
      CLINT_MSIP:     rd_sample = {31'd0, msip_q};
      CLINT_CMP_LO:   rd_sample = mtimecmp_q[31:0];
      CLINT_CMP_HI:   rd_sample = mtimecmp_q[63:32];
`endif
      default:        rd_sample = 32'd0;
    endcase
  end

  assign axi_clint.arready = rd_idle;
  assign axi_clint.rvalid  = !rd_idle;
  assign axi_clint.rdata   = rdata_q;
  assign axi_clint.rresp   = rresp_q;
  assign axi_clint.rid     = rid_q;
  assign axi_clint.rlast   = rd_last;

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    roff_d     = roff_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: if (axi_clint.arvalid) begin
        rd_state_d = R_DATA;
        rid_d      = axi_clint.arid;
        roff_d     = rd_off;
        rlen_d     = axi_clint.arlen;
        rbeat_d    = 8'd0;
        rdata_d    = rd_sample;
        rresp_d    = rd_resp;
      end
      R_DATA: if (axi_clint.rready) begin
        if (rd_last) begin
          rd_state_d = R_IDLE;
        end else begin
          rbeat_d = rbeat_q + 8'd1;
          rdata_d = rd_sample;
          rresp_d = rd_resp;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign axi_clint.awready = (wr_state_q == W_IDLE) && !aw_got_q;
  assign axi_clint.wready  = (wr_state_q == W_IDLE) && !w_got_q;
  assign axi_clint.bvalid  = (wr_state_q == W_RESP);
  assign axi_clint.bresp   = bresp_q;
  assign axi_clint.bid     = bid_q;

  assign aw_hs   = axi_clint.awvalid && axi_clint.awready;
  assign w_hs    = axi_clint.wvalid && axi_clint.wready;
  assign commit  = (wr_state_q == W_COMMIT);
  assign wr_resp = (wlen_q != 8'd0) ? AXI_SLVERR :
                   clint_mapped(woff_q) ? AXI_OKAY : AXI_DECERR;
  assign wr_ok   = commit && (wr_resp == AXI_OKAY);

  // W is considered complete on wlast, so bursts are drained beat by beat
  // without knowing awlen when W runs ahead of AW.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    bid_d      = bid_q;
    woff_d     = woff_q;
    wlen_d     = wlen_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          bid_d    = axi_clint.awid;
          woff_d   = {axi_clint.awaddr[15:2], 2'b00};
          wlen_d   = axi_clint.awlen;
        end
        if (w_hs) begin
          wdata_d = axi_clint.wdata;
          wstrb_d = axi_clint.wstrb;
          if (axi_clint.wlast) w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        bresp_d    = wr_resp;
        wr_state_d = W_RESP;
      end
      W_RESP: if (axi_clint.bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  ysyx_24080006_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .wr_lo_i (wr_ok && (woff_q == CLINT_MTIME_LO)),
    .wr_hi_i (wr_ok && (woff_q == CLINT_MTIME_HI)),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .mtime_o (mtime)
  );

`ifdef CLINT_CMP_EN
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_ok && (woff_q == CLINT_MSIP) && wstrb_q[0]) msip_d = wdata_q[0];
    for (int b = 0; b < 4; b++) begin
      if (wr_ok && (woff_q == CLINT_CMP_LO) && wstrb_q[b])
        mtimecmp_d[8*b +: 8] = wdata_q[8*b +: 8];
      if (wr_ok && (woff_q == CLINT_CMP_HI) && wstrb_q[b])
        mtimecmp_d[32+8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      soft_irq_q  <= 1'b0;
    end else begin
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= (mtime >= mtimecmp_q);
      soft_irq_q  <= msip_q;
    end
  end

  assign timer_irq = timer_irq_q;
  assign soft_irq  = soft_irq_q;
`else
  assign timer_irq = 1'b0;
  assign soft_irq  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      roff_q     <= 16'd0;
      rlen_q     <= 8'd0;
      rbeat_q    <= 8'd0;
      rdata_q    <= 32'd0;
      rresp_q    <= AXI_OKAY;
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      bid_q      <= '0;
      woff_q     <= 16'd0;
      wlen_q     <= 8'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      bresp_q    <= AXI_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      roff_q     <= roff_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      bid_q      <= bid_d;
      woff_q     <= woff_d;
      wlen_q     <= wlen_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_clint.sv
// Directed bench for ysyx_24080006_clint (TICK_DIV=1). Expected mtime values
// come from a bench-side cycle counter: with TICK_DIV=1, mtime in cycle k
// after reset release equals k until software writes mtime.
module tb_ysyx_24080006_clint;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic timer_irq, soft_irq;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned cyc;

`ifdef CLINT_CMP_EN
  localparam logic [1:0] CMP_RESP = 2'b00;
  localparam logic       CMP_ON   = 1'b1;
`else
  localparam logic [1:0] CMP_RESP = 2'b11;
  localparam logic       CMP_ON   = 1'b0;
`endif

  ysyx_24080006_axi #(.ID_W(4)) axi_clint ();

  ysyx_24080006_clint #(
    .BASE     (32'h0200_0000),
    .TICK_DIV (1),
    .ID_W     (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .axi_clint (axi_clint),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] rd_data [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];
  logic [3:0]  rd_id   [8];
  int unsigned rd_cyc  [8];
  int          rd_beats;
  int          wr_wait;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;
  int unsigned wr_bcyc;
  logic        wr_bv_after;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int guard;
    axi_clint.araddr  = addr;
    axi_clint.arlen   = len;
    axi_clint.arid    = id;
    axi_clint.arsize  = 3'd2;
    axi_clint.arvalid = 1'b1;
    guard = 0;
    while (!axi_clint.arready && guard < 20) begin
      @(posedge clock); #1; guard++;
    end
    @(posedge clock); #1;
    axi_clint.arvalid = 1'b0;
    rd_beats = 0;
    guard = 0;
    while (rd_beats <= int'(len) && rd_beats < 8 && guard < 20) begin
      if (axi_clint.rvalid) begin
        rd_data[rd_beats] = axi_clint.rdata;
        rd_resp[rd_beats] = axi_clint.rresp;
        rd_last[rd_beats] = axi_clint.rlast;
        rd_id[rd_beats]   = axi_clint.rid;
        rd_cyc[rd_beats]  = cyc;
        rd_beats++;
      end
      @(posedge clock); #1; guard++;
    end
  endtask

  // lead > 0: W beat is presented lead cycles ahead of AW (single beat only).
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [7:0] len, input logic [3:0] id, input int lead);
    int guard;
    axi_clint.awaddr = addr;
    axi_clint.awlen  = len;
    axi_clint.awid   = id;
    axi_clint.awsize = 3'd2;
    axi_clint.wdata  = data;
    axi_clint.wstrb  = strb;
    if (lead > 0) begin
      axi_clint.wvalid = 1'b1;
      axi_clint.wlast  = 1'b1;
      @(posedge clock); #1;
      axi_clint.wvalid = 1'b0;
      axi_clint.wlast  = 1'b0;
      check("wready_drop", axi_clint.wready, 0);
      check("awready_hold", axi_clint.awready, 1);
      repeat (lead - 1) begin @(posedge clock); #1; end
      axi_clint.awvalid = 1'b1;
      @(posedge clock); #1;
      axi_clint.awvalid = 1'b0;
    end else begin
      axi_clint.awvalid = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
        axi_clint.wvalid = 1'b1;
        axi_clint.wlast  = (i == int'(len));
        @(posedge clock); #1;
        axi_clint.awvalid = 1'b0;
      end
      axi_clint.wvalid = 1'b0;
      axi_clint.wlast  = 1'b0;
    end
    guard = 0;
    while (!axi_clint.bvalid && guard < 20) begin
      @(posedge clock); #1; guard++;
    end
    wr_wait = guard;
    wr_resp = axi_clint.bresp;
    wr_id   = axi_clint.bid;
    wr_bcyc = cyc;
    @(posedge clock); #1;
    wr_bv_after = axi_clint.bvalid;
  endtask

  initial begin
    int unsigned t_hs, t_cmp;
    int guard;
    axi_clint.awvalid = 0; axi_clint.awaddr = 0; axi_clint.awid = 0;
    axi_clint.awlen = 0; axi_clint.awsize = 0;
    axi_clint.wvalid = 0; axi_clint.wdata = 0; axi_clint.wstrb = 0; axi_clint.wlast = 0;
    axi_clint.bready = 1;
    axi_clint.arvalid = 0; axi_clint.araddr = 0; axi_clint.arid = 0;
    axi_clint.arlen = 0; axi_clint.arsize = 0;
    axi_clint.rready = 1;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state (cycle 0)
    check("rst_arready", axi_clint.arready, 1);
    check("rst_awready", axi_clint.awready, 1);
    check("rst_wready", axi_clint.wready, 1);
    check("rst_rvalid", axi_clint.rvalid, 0);
    check("rst_bvalid", axi_clint.bvalid, 0);
    check("rst_rlast", axi_clint.rlast, 0);
    check("rst_rresp", axi_clint.rresp, 0);
    check("rst_bresp", axi_clint.bresp, 0);
    check("rst_timer_irq", timer_irq, 0);
    check("rst_soft_irq", soft_irq, 0);

    // mtime read with handshake in cycle 10
    repeat (10) @(posedge clock);
    #1;
    axi_read(32'h0200_BFF8, 8'd0, 4'h5);
    check("t10_beats", rd_beats, 1);
    check("t10_rdata", rd_data[0], 10);
    check("t10_rresp", rd_resp[0], 0);
    check("t10_rlast", rd_last[0], 1);
    check("t10_rid", rd_id[0], 4'h5);
    check("t10_rvalid_cycle", rd_cyc[0], 11);
    check("t10_arready_back", axi_clint.arready, 1);

    axi_read(32'h0200_BFFC, 8'd0, 4'h1);
    check("mtime_hi_rdata", rd_data[0], 0);
    check("mtime_hi_rresp", rd_resp[0], 0);

    axi_read(32'h0200_1234, 8'd0, 4'h3);
    check("unmapped_rresp", rd_resp[0], 2'b11);
    check("unmapped_rdata", rd_data[0], 0);
    check("unmapped_rid", rd_id[0], 4'h3);

    // addr[1:0] ignored
    axi_read(32'h0200_BFFA, 8'd0, 4'h7);
    check("alias_rresp", rd_resp[0], 0);
    check("alias_rdata", rd_data[0], rd_cyc[0] - 1);

    // 4-beat burst: SLVERR every beat, fresh sample each beat, rlast on beat 4
    axi_read(32'h0200_BFF8, 8'd3, 4'h9);
    check("burst_beats", rd_beats, 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("burst_rresp%0d", j), rd_resp[j], 2'b10);
      check($sformatf("burst_rlast%0d", j), rd_last[j], (j == 3));
      check($sformatf("burst_rid%0d", j), rd_id[j], 4'h9);
      check($sformatf("burst_rdata%0d", j), rd_data[j], rd_cyc[j] - 1);
    end

    // rready stall: response held stable, no new AR accepted
    axi_clint.rready  = 1'b0;
    axi_clint.araddr  = 32'h0200_BFF8;
    axi_clint.arlen   = 8'd0;
    axi_clint.arid    = 4'h2;
    axi_clint.arvalid = 1'b1;
    t_hs = cyc;
    @(posedge clock); #1;
    axi_clint.arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_rvalid", axi_clint.rvalid, 1);
      check("stall_rdata", axi_clint.rdata, t_hs);
      check("stall_arready", axi_clint.arready, 0);
      @(posedge clock); #1;
    end
    check("stall_rid", axi_clint.rid, 4'h2);
    axi_clint.rready = 1'b1;
    @(posedge clock); #1;
    check("stall_done_rvalid", axi_clint.rvalid, 0);
    check("stall_done_arready", axi_clint.arready, 1);

    // mtimecmp lo write (all ones keeps reset value when present)
    axi_write(32'h0200_4000, 32'hFFFF_FFFF, 4'hF, 8'd0, 4'hA, 0);
    check("cmp_lo_bresp", wr_resp, CMP_RESP);
    check("cmp_lo_bid", wr_id, 4'hA);
    check("cmp_lo_latency", wr_wait, 1);
    check("cmp_lo_single_b", wr_bv_after, 0);
    check("cmp_lo_timer_irq", timer_irq, 0);

`ifdef CLINT_CMP_EN
    axi_write(32'h0200_4004, 32'h0, 4'hF, 8'd0, 4'h1, 0);
    check("cmp_hi0_bresp", wr_resp, 0);
    t_cmp = cyc + 40;
    axi_write(32'h0200_4000, t_cmp, 4'hF, 8'd0, 4'h1, 0);
    check("cmp_set_bresp", wr_resp, 0);
    check("cmp_set_irq_low", timer_irq, 0);
    guard = 0;
    while (cyc < t_cmp && guard < 100) begin @(posedge clock); #1; guard++; end
    check("cmp_at_t_irq", timer_irq, 0);
    @(posedge clock); #1;
    check("cmp_after_t_irq", timer_irq, 1);
    axi_write(32'h0200_4000, 32'hFFFF_FFFF, 4'hF, 8'd0, 4'h1, 0);
    check("cmp_clear_irq", timer_irq, 0);
`endif

    // W three cycles ahead of AW to msip
    axi_write(32'h0200_0000, 32'h0000_0001, 4'b0001, 8'd0, 4'h6, 3);
    check("msip_bresp", wr_resp, CMP_RESP);
    check("msip_bid", wr_id, 4'h6);
    check("msip_latency", wr_wait, 1);
    check("msip_single_b", wr_bv_after, 0);
    check("msip_soft_irq", soft_irq, CMP_ON);
    axi_write(32'h0200_0000, 32'h0000_0000, 4'b0000, 8'd0, 4'h6, 0);
    check("msip_strb0_bresp", wr_resp, CMP_RESP);
    check("msip_strb0_soft_irq", soft_irq, CMP_ON);
    axi_read(32'h0200_0000, 8'd0, 4'h4);
    check("msip_rd_rresp", rd_resp[0], CMP_RESP);
    check("msip_rd_rdata", rd_data[0], CMP_ON);

    // Burst write and unmapped write leave mtime alone
    axi_write(32'h0200_BFF8, 32'h0, 4'hF, 8'd1, 4'hB, 0);
    check("wburst_bresp", wr_resp, 2'b10);
    check("wburst_bid", wr_id, 4'hB);
    check("wburst_latency", wr_wait, 1);
    axi_write(32'h0200_2000, 32'h0, 4'hF, 8'd0, 4'hC, 0);
    check("wunmapped_bresp", wr_resp, 2'b11);
    axi_read(32'h0200_BFF8, 8'd0, 4'h0);
    check("mtime_untouched", rd_data[0], rd_cyc[0] - 1);

    // mtime carry from lo into hi; commit cycle holds the written value
    axi_write(32'h0200_BFFC, 32'h0, 4'hF, 8'd0, 4'hD, 0);
    check("mtime_hi_wr_bresp", wr_resp, 0);
    axi_write(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 8'd0, 4'hD, 0);
    check("mtime_lo_wr_bresp", wr_resp, 0);
    t_hs = wr_bcyc;
    axi_read(32'h0200_BFFC, 8'd0, 4'h0);
    check("carry_hi", rd_data[0], 1);
    axi_read(32'h0200_BFF8, 8'd0, 4'h0);
    check("carry_lo", rd_data[0], rd_cyc[0] - 1 - t_hs - 1);

    // byte-masked hi write: lanes 0 and 2 only
    axi_write(32'h0200_BFFC, 32'hAABB_CCDD, 4'b0101, 8'd0, 4'hE, 0);
    axi_read(32'h0200_BFFC, 8'd0, 4'h0);
    check("mask_hi", rd_data[0], 32'h00BB_00DD);

    // full 64-bit wrap to zero
    axi_write(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, 8'd0, 4'h1, 0);
    axi_write(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 8'd0, 4'h1, 0);
    t_hs = wr_bcyc;
    axi_read(32'h0200_BFFC, 8'd0, 4'h0);
    check("wrap_hi", rd_data[0], 0);
    axi_read(32'h0200_BFF8, 8'd0, 4'h0);
    check("wrap_lo", rd_data[0], rd_cyc[0] - 1 - t_hs - 1);
    check("end_timer_irq", timer_irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
